// File: rtl/ws2812b_pkg.sv
`default_nettype none
// ============================================================================
// ws2812b_pkg : shared WS2812B timing constants, pixel and receiver types
// Rev 1.0
// ============================================================================
package ws2812b_pkg;

  localparam int T0H_NS      = 400;
  localparam int T1H_NS      = 800;
  localparam int T0L_NS      = 850;
  localparam int T1L_NS      = 450;
  localparam int T_RESET_NS  = 50000;
  localparam int T_THRESH_NS = 600;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } rx_state_t;

  // Rounds up so a threshold is never shorter than its nanosecond value.
  function automatic int ns_to_cycles(input longint t_ns, input longint clk_hz);
    return int'((t_ns * clk_hz + longint'(999_999_999)) / longint'(1_000_000_000));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812b_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// sync_edge : multi-stage synchronizer with registered rise/fall strobes
// Rev 1.0
// ============================================================================
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              level_q;
  logic              rise_q;
  logic              fall_q;

  // Strobes are registered together with level_q so all three stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_i};
      level_q <= sync_q[STAGES-1];
      rise_q  <= sync_q[STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[STAGES-1] & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/ws2812b_rx.sv
`default_nettype none
// ============================================================================
// ws2812b_rx : WS2812B single-wire decoder producing indexed GRB pixel words
// Rev 1.0
// ============================================================================
module ws2812b_rx #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int T_MIN_NS      = 100,
  parameter int T_THRESH_NS   = 600,
  parameter int T_HIGH_MAX_NS = 5000,
  parameter int T_RESET_NS    = 50000,
  parameter int NB_LEDS       = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] color,
  output logic [31:0] pixel_index,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic        overflow,
  output logic        err
);

  import ws2812b_pkg::*;

  localparam int N_MIN    = ns_to_cycles(T_MIN_NS, CLK_HZ);
  localparam int N_THRESH = ns_to_cycles(T_THRESH_NS, CLK_HZ);
  localparam int N_MAX    = ns_to_cycles(T_HIGH_MAX_NS, CLK_HZ);
  localparam int N_RESET  = ns_to_cycles(T_RESET_NS, CLK_HZ);
  localparam int HW       = $clog2(N_MAX + 2);
  localparam int LW       = $clog2(N_RESET + 1);
  localparam int PW       = $clog2(NB_LEDS + 2);

  logic din_lvl, din_rise, din_fall;

  sync_edge #(.STAGES(2)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (din),
    .level_o (din_lvl),
    .rise_o  (din_rise),
    .fall_o  (din_fall)
  );

  rx_state_t   state_q, state_d;
  logic [HW-1:0] high_q, high_d;
  logic [LW-1:0] low_q, low_d;
  logic [22:0] shift_q, shift_d;
  logic [4:0]  bits_q, bits_d;
  logic [PW-1:0] pix_q, pix_d;
  logic        any_bit_q, any_bit_d;
  grb_t        color_q, color_d;
  logic [31:0] index_q, index_d;
  logic        pv_q, pv_d, fd_q, fd_d, ov_q, ov_d, err_q, err_d;
  logic [23:0] new_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SYNC;
      high_q    <= '0;
      low_q     <= '0;
      shift_q   <= '0;
      bits_q    <= '0;
      pix_q     <= '0;
      any_bit_q <= 1'b0;
      color_q   <= '0;
      index_q   <= '0;
      pv_q      <= 1'b0;
      fd_q      <= 1'b0;
      ov_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      high_q    <= high_d;
      low_q     <= low_d;
      shift_q   <= shift_d;
      bits_q    <= bits_d;
      pix_q     <= pix_d;
      any_bit_q <= any_bit_d;
      color_q   <= color_d;
      index_q   <= index_d;
      pv_q      <= pv_d;
      fd_q      <= fd_d;
      ov_q      <= ov_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    high_d    = high_q;
    low_d     = low_q;
    shift_d   = shift_q;
    bits_d    = bits_q;
    pix_d     = pix_q;
    any_bit_d = any_bit_q;
    color_d   = color_q;
    index_d   = index_q;
    pv_d      = 1'b0;
    fd_d      = 1'b0;
    ov_d      = 1'b0;
    err_d     = 1'b0;
    new_word  = {shift_q, (high_q >= HW'(N_THRESH))};
    unique case (state_q)
      S_SYNC: begin
        if (din_lvl) begin
          low_d = '0;
        end else if (low_q >= LW'(N_RESET - 1)) begin
          low_d     = LW'(N_RESET);
          state_d   = S_LOW;
          bits_d    = '0;
          pix_d     = '0;
          any_bit_d = 1'b0;
        end else begin
          low_d = low_q + 1'b1;
        end
      end
      S_LOW: begin
        // The rising cycle is already the first high cycle of the pulse.
        if (din_rise) begin
          high_d  = HW'(1);
          state_d = S_HIGH;
        end else if (low_q != LW'(N_RESET)) begin
          low_d = low_q + 1'b1;
          if (low_q == LW'(N_RESET - 1)) begin
            fd_d      = any_bit_q;
            err_d     = (bits_q != 5'd0);
            bits_d    = '0;
            pix_d     = '0;
            any_bit_d = 1'b0;
          end
        end
      end
      S_HIGH: begin
        if (din_fall) begin
          state_d = S_LOW;
          low_d   = LW'(1);
          if (high_q < HW'(N_MIN)) begin
            err_d = 1'b1;
          end else begin
            shift_d   = new_word[22:0];
            any_bit_d = 1'b1;
            if (bits_q == 5'd23) begin
              bits_d = '0;
              if (pix_q < PW'(NB_LEDS)) begin
                color_d = new_word;
                index_d = 32'(pix_q);
                pv_d    = 1'b1;
              end else if (pix_q == PW'(NB_LEDS)) begin
                ov_d = 1'b1;
              end
              if (pix_q != PW'(NB_LEDS + 1)) pix_d = pix_q + 1'b1;
            end else begin
              bits_d = bits_q + 1'b1;
            end
          end
        end else if (high_q >= HW'(N_MAX)) begin
          err_d   = 1'b1;
          state_d = S_SYNC;
          low_d   = '0;
          bits_d  = '0;
        end else begin
          high_d = high_q + 1'b1;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  assign color       = color_q;
  assign pixel_index = index_q;
  assign pixel_valid = pv_q;
  assign frame_done  = fd_q;
  assign overflow    = ov_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: doc/ws2812b_rx.md
Name: ws2812b_rx

Overview:
- Single-wire WS2812B stream decoder. It is the receive end of the protocol driven by the ws2812b strip transmitter.
- Measures high-pulse widths on an asynchronous data line, assembles 24-bit GRB words, and reports each pixel with its index in the frame.
- Detects the latch (reset) gap and flags malformed pulses.
- Used as an on-FPGA loopback monitor for the strip driver and as a pixel emulator.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency. All cycle thresholds are derived from it.
- T_MIN_NS, 100: high pulses shorter than this are glitches.
- T_THRESH_NS, 600: high pulse >= threshold decodes as 1, shorter decodes as 0.
- T_HIGH_MAX_NS, 5000: high pulse longer than this is an error.
- T_RESET_NS, 50000: low time >= this is the latch gap.
- NB_LEDS, 15: pixels reported per frame. Later pixels in the same frame are dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- din  in  1  serial data line, asynchronous to clk
- color  out  24  decoded word, wire order: [23:16]=G, [15:8]=R, [7:0]=B. First received bit lands in bit 23.
- pixel_index  out  32  index of the word in color (0-based within frame)
- pixel_valid  out  1  one-cycle strobe; color and pixel_index are valid while it is high
- frame_done  out  1  one-cycle strobe at latch gap, only if the frame delivered at least one bit
- overflow  out  1  one-cycle strobe when pixel NB_LEDS completes in a frame (once per frame)
- err  out  1  one-cycle strobe on a protocol error

Behaviour:
- Cycle counts: N_MIN, N_THRESH, N_MAX, N_RESET = ceil(T_x_NS * CLK_HZ / 1e9). At 100 MHz these are 10, 60, 500, 5000.
- Counters are sized with $clog2 and saturate; they never wrap.
- Input conditioning: din passes through a 2-FF synchronizer, then a registered copy for edge detection. Rising and falling edges are taken from the synchronized signal.
- Reset: all outputs are 0, color=0, pixel_index=0. Shift register, bit count, pixel count and counters clear. State = S_SYNC.
- S_SYNC:
  - Count consecutive low cycles; any high clears the count.
  - On reaching N_RESET, go to S_LOW with frame empty. No frame_done.
  - Rst mid-frame therefore discards the rest of that frame.
- S_LOW:
  - Count low cycles.
  - On a rising edge, clear the high counter and go to S_HIGH.
  - When low count reaches N_RESET:
    - Pulse frame_done if the frame had any bit.
    - Pulse err in the same cycle if the bit count is nonzero (partial word); the partial word is discarded.
    - Clear bit count and pixel count, and stay in S_LOW.
  - frame_done pulses exactly once per gap.
- S_HIGH:
  - Count high cycles.
  - If the count exceeds N_MAX: pulse err, discard the partial word, go to S_SYNC.
  - On a falling edge with count < N_MIN: pulse err, drop the bit, go to S_LOW.
  - Otherwise shift in the bit (count >= N_THRESH gives 1) and return to S_LOW.
  - A count exactly at N_THRESH decodes as 1.
- Word completion, on the cycle the 24th bit shifts in:
  - If pixel count < NB_LEDS: register color and pixel_index=pixel count, and assert pixel_valid on the next cycle.
  - If pixel count == NB_LEDS: pulse overflow instead, and pulse it only once.
  - Pixel count increments, saturating at NB_LEDS+1. Bit count resets to 0.
- Latency: din falling edge of the 24th bit to pixel_valid high = 4 clk cycles (2 sync, 1 edge, 1 output register). Fixed and tested.
- color and pixel_index hold their value between strobes.
- Simultaneous events are impossible by construction, since the gap check runs only while low and bit decisions occur only on falling edges. err and frame_done may coincide as described above.
- No backpressure: the consumer must accept pixel_valid when it occurs. The minimum spacing between strobes is 24 bit periods.

Decomposition:
- Package ws2812b_pkg:
  - Nominal timing constants in ns: T0H=400, T1H=800, T0L=850, T1L=450, T_RESET_NS=50000, T_THRESH_NS=600.
  - Typedef grb_t (packed struct g, r, b of 8 bits each).
  - State enum rx_state_t {S_SYNC, S_LOW, S_HIGH}.
  - The transmitter imports the same timing constants.
- Sub-module sync_edge (2-FF synchronizer plus rise/fall strobes, param STAGES=2), reusable for other async inputs.

Test Plan:
- Bit-exact: rst, 60 us low, then 24 bits encoding 0x00FF00 with nominal timing, then a 60 us gap -> one pixel_valid with color=0x00FF00, pixel_index=0; then frame_done; err never asserted.
- Loopback: ws2812b transmitter with NB_LEDS=15 writing 0xFFFFFF to LED 2 -> 15 pixel_valid strobes, indices 0..14, index 2 = 0xFFFFFF; one frame_done.
- Threshold: high pulses of 59 and 60 cycles -> decoded as 0 and 1 respectively; a 9-cycle high pulse -> err, bit dropped.
- Stuck high: din high for 501 cycles mid-word -> err on cycle 501; no pixel_valid until a 5000-cycle low gap plus a fresh word.
- Partial word/overflow: 16 bits then a gap -> err and frame_done in the same cycle, no pixel_valid. 16 pixels with NB_LEDS=15 -> 15 pixel_valid strobes, then 1 overflow.
- Reset mid-frame: assert rst after bit 10 of a word, then continue the stream -> no output until a 50 us gap; the next word decodes at index 0.
